telemetry_frame_tx: RTL and testbench

Serial telemetry transmitter for the converter datapath: accepts 8-bit converter output samples over a valid/ready handshake, buffers a fixed number of them, and ships each batch to the host as one framed 8N1 UART burst. Frame layout: sync byte, length, samples, XOR checksum. Sits downstream of the converter core, which drives `uo_out`, and feeds the chip's serial output pin. It is the sending end of the host-side telemetry link.

---
 rtl/telemetry_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 71 +++++++
 rtl/telemetry_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_telemetry_frame_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// telemetry_pkg
// Shared definitions for the telemetry frame transmitter slice.
//   tx_state_t        : frame FSM states (collect samples, then send the
//                       sync, length, data and checksum bytes)
//   UART_FRAME_BITS   : bits per serial character (start + 8 data + stop)
//   DEFAULT_SYNC_BYTE : marker byte that opens every frame
package telemetry_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SEND_SYNC,
    ST_SEND_LEN,
    ST_SEND_DATA,
    ST_SEND_CSUM
  } tx_state_t;

  localparam int UART_FRAME_BITS = 10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Serialises one byte as an 8N1 character: start bit (0), eight data bits
// LSB first, stop bit (1). Every bit is held for CLKS_PER_BIT cycles.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, forces the line idle (high)
//   start : begin sending data; honoured when idle or on the done cycle
//   data  : byte to send, captured on the start edge
//   tx    : registered serial line output, idle high
//   done  : high during the final cycle of the stop bit, so the caller can
//           raise start in that same cycle and get back-to-back characters
module uart_tx_byte
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic             active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] bit_cnt;
  logic [8:0]       shreg;

  // The last cycle of the stop bit is flagged combinationally from the
  // counters, which is what lets a new start bit follow with no idle gap.
  assign done = active && (bit_idx == LAST_BIT) && (bit_cnt == LAST_CNT);

  // Bit sequencer. The start bit is driven straight onto tx when the byte
  // is accepted; the shift register holds the remaining data bits plus the
  // stop bit and shifts in ones so the line falls back to idle naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      tx      <= 1'b1;
      bit_idx <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
    end else if (start && (!active || done)) begin
      active  <= 1'b1;
      tx      <= 1'b0;
      shreg   <= {1'b1, data};
      bit_idx <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (bit_cnt == LAST_CNT) begin
        bit_cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/telemetry_frame_tx.sv
// telemetry_frame_tx
// Collects FRAME_SAMPLES converter samples over a valid/ready handshake and
// sends them to the host as one 8N1 burst: SYNC, LEN, samples, checksum,
// where checksum is the XOR of LEN and all samples.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, abandons any frame in flight
//   in_data    : 8-bit converter sample
//   in_valid   : in_data is valid
//   in_ready   : registered; high while collecting samples
//   tx         : serial output, idle high
//   busy       : high while a frame is on the wire
//   frame_done : one-cycle pulse after the checksum stop bit completes
module telemetry_frame_tx
  import telemetry_pkg::*;
#(
  parameter int          CLKS_PER_BIT  = 868,
  parameter int          FRAME_SAMPLES = 4,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int IDX_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SAMPLES - 1);
  localparam logic [7:0] LEN_BYTE = 8'(FRAME_SAMPLES);

  tx_state_t        state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       csum;
  logic [7:0]       sample_buf [FRAME_SAMPLES];

  logic       accept;
  logic       last_sample;
  logic       uart_start;
  logic       uart_done;
  logic [7:0] uart_data;

  assign accept      = (state == ST_COLLECT) && in_valid && in_ready;
  assign last_sample = (cnt == LAST_IDX);

  // Chooses the next byte for the serialiser. The final sample transfer
  // launches SYNC directly so its start bit begins on the following cycle,
  // and every later byte is launched during the previous byte's last stop
  // bit cycle. The checksum byte folds LEN into the running sample XOR.
  always_comb begin
    uart_start = 1'b0;
    uart_data  = SYNC_BYTE;
    case (state)
      ST_COLLECT: begin
        if (accept && last_sample) begin
          uart_start = 1'b1;
        end
      end
      ST_SEND_SYNC: begin
        if (uart_done) begin
          uart_start = 1'b1;
          uart_data  = LEN_BYTE;
        end
      end
      ST_SEND_LEN: begin
        if (uart_done) begin
          uart_start = 1'b1;
          uart_data  = sample_buf[0];
        end
      end
      ST_SEND_DATA: begin
        if (uart_done) begin
          uart_start = 1'b1;
          if (byte_idx == LAST_IDX) begin
            uart_data = csum ^ LEN_BYTE;
          end else begin
            uart_data = sample_buf[byte_idx + IDX_W'(1)];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Sample storage. Contents are irrelevant after reset, so the buffer is
  // only ever written on an accepted transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_buf[cnt] <= in_data;
    end
  end

  // Frame FSM with registered handshake and status outputs. in_ready is
  // re-asserted on every collecting cycle, which makes it rise on the first
  // edge that sees reset low, and it drops together with the final transfer
  // so nothing is accepted while a frame is being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_COLLECT;
      cnt        <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            csum <= csum ^ in_data;
            if (last_sample) begin
              cnt      <= '0;
              state    <= ST_SEND_SYNC;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        ST_SEND_SYNC: begin
          if (uart_done) begin
            state <= ST_SEND_LEN;
          end
        end
        ST_SEND_LEN: begin
          if (uart_done) begin
            state    <= ST_SEND_DATA;
            byte_idx <= '0;
          end
        end
        ST_SEND_DATA: begin
          if (uart_done) begin
            if (byte_idx == LAST_IDX) begin
              state    <= ST_SEND_CSUM;
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        ST_SEND_CSUM: begin
          if (uart_done) begin
            state      <= ST_COLLECT;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b1;
            csum       <= '0;
          end
        end
        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start),
    .data (uart_data),
    .tx   (tx),
    .done (uart_done)
  );

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb_telemetry_frame_tx
// Three instances share one clock: a 4-sample frame and a 1-sample frame at
// 4 clocks per bit, and a 1-sample frame at 868 clocks per bit. Expected
// frames are built from the sample list (SYNC, LEN, samples, XOR of LEN and
// samples) and the serial line is compared against the ideal 8N1 waveform
// cycle by cycle, with bytes also decoded at mid-bit.
module tb_telemetry_frame_tx;

  logic       clk;
  logic       rst        [3];
  logic [7:0] in_data    [3];
  logic       in_valid   [3];
  logic       in_ready   [3];
  logic       tx         [3];
  logic       busy       [3];
  logic       frame_done [3];

  int compares = 0;
  int fails    = 0;

  logic [7:0] smp_q [$];
  logic [7:0] exp_q [$];

  telemetry_frame_tx #(.CLKS_PER_BIT(4), .FRAME_SAMPLES(4), .SYNC_BYTE(8'hA5)) dut_quad (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  telemetry_frame_tx #(.CLKS_PER_BIT(4), .FRAME_SAMPLES(1), .SYNC_BYTE(8'hA5)) dut_single (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  telemetry_frame_tx #(.CLKS_PER_BIT(868), .FRAME_SAMPLES(1), .SYNC_BYTE(8'hA5)) dut_slow (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2])
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cpb_of(input int d);
    return (d == 2) ? 868 : 4;
  endfunction

  function automatic int nsmp_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Reference frame for the current sample list.
  function automatic void build_expected(input int d);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'(nsmp_of(d));
    exp_q.push_back(x);
    foreach (smp_q[i]) begin
      exp_q.push_back(smp_q[i]);
      x = x ^ smp_q[i];
    end
    exp_q.push_back(x);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents every sample of smp_q through the handshake. Called at a
  // negedge; returns at the negedge after the last transfer.
  task automatic applyStimulus(input int d);
    for (int i = 0; i < smp_q.size(); i++) begin
      int waited;
      waited = 0;
      in_data[d]  = smp_q[i];
      in_valid[d] = 1'b1;
      while (!in_ready[d] && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("in_ready_for_sample", {31'b0, in_ready[d]}, 32'd1);
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
  endtask

  // Walks a whole frame cycle by cycle against exp_q. Without wait_start the
  // current negedge must already be the first cycle of the SYNC start bit.
  task automatic checkFrame(input int d, input bit wait_start);
    int cpb;
    int waited;
    int ctl_err;
    cpb     = cpb_of(d);
    waited  = 0;
    ctl_err = 0;
    if (wait_start) begin
      while (!busy[d] && waited < 200) begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput("busy_at_frame_start", {31'b0, busy[d]}, 32'd1);
    for (int b = 0; b < exp_q.size(); b++) begin
      logic [9:0] bits;
      logic [7:0] decoded;
      int         wave_err;
      bits     = {1'b1, exp_q[b], 1'b0};
      decoded  = 8'h00;
      wave_err = 0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int c = 0; c < cpb; c++) begin
          if (!(b == 0 && bi == 0 && c == 0)) @(negedge clk);
          if (tx[d] !== bits[bi]) wave_err++;
          if (c == cpb / 2 && bi >= 1 && bi <= 8) decoded[bi-1] = tx[d];
          if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0 || frame_done[d] !== 1'b0) ctl_err++;
        end
      end
      checkOutput($sformatf("dut%0d_byte%0d_value", d, b), {24'b0, decoded}, {24'b0, exp_q[b]});
      checkOutput($sformatf("dut%0d_byte%0d_bad_cycles", d, b), wave_err, 0);
    end
    checkOutput("frame_control_bad_cycles", ctl_err, 0);
    @(negedge clk);
    checkOutput("frame_done_pulse", {31'b0, frame_done[d]}, 32'd1);
    checkOutput("busy_after_frame", {31'b0, busy[d]}, 32'd0);
    checkOutput("in_ready_after_frame", {31'b0, in_ready[d]}, 32'd1);
    checkOutput("tx_idle_after_frame", {31'b0, tx[d]}, 32'd1);
  endtask

  // Directed sequence: reset, nominal and random frames, backpressure,
  // mid-frame reset, single-sample frames and slow bit timing.
  initial begin
    logic [7:0] base;
    int         bp_count;
    int         pulses;
    int         tx_low;

    for (int d = 0; d < 3; d++) begin
      rst[d]      = 1'b1;
      in_valid[d] = 1'b1;
      in_data[d]  = 8'($urandom);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checkOutput("reset_tx", {31'b0, tx[d]}, 32'd1);
        checkOutput("reset_in_ready", {31'b0, in_ready[d]}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy[d]}, 32'd0);
        checkOutput("reset_frame_done", {31'b0, frame_done[d]}, 32'd0);
      end
    end
    for (int d = 0; d < 3; d++) begin
      rst[d]      = 1'b0;
      in_valid[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("in_ready_after_release", {31'b0, in_ready[d]}, 32'd1);
      checkOutput("tx_idle_after_release", {31'b0, tx[d]}, 32'd1);
    end

    $display("[TB] nominal frame");
    smp_q = '{8'h32, 8'h5A, 8'h00, 8'hFF};
    build_expected(0);
    applyStimulus(0);
    checkFrame(0, 1'b0);

    $display("[TB] random frames");
    for (int r = 0; r < 2; r++) begin
      smp_q.delete();
      for (int i = 0; i < 4; i++) smp_q.push_back(8'($urandom));
      build_expected(0);
      applyStimulus(0);
      checkFrame(0, 1'b0);
    end

    $display("[TB] backpressure across two frames");
    base     = 8'($urandom);
    bp_count = 0;
    smp_q.delete();
    for (int i = 0; i < 4; i++) smp_q.push_back(8'(base + i));
    build_expected(0);
    fork
      begin
        int  cnt;
        logic acc;
        cnt = 0;
        in_data[0]  = base;
        in_valid[0] = 1'b1;
        acc = in_ready[0];
        for (int it = 0; it < 2000 && cnt < 8; it++) begin
          @(negedge clk);
          if (acc) begin
            cnt++;
            in_data[0] = 8'(base + cnt);
          end
          acc = in_ready[0] && (cnt < 8);
        end
        in_valid[0] = 1'b0;
        bp_count = cnt;
      end
      begin
        checkFrame(0, 1'b1);
        smp_q.delete();
        for (int i = 4; i < 8; i++) smp_q.push_back(8'(base + i));
        build_expected(0);
        checkFrame(0, 1'b1);
      end
    join
    checkOutput("backpressure_samples_accepted", bp_count, 8);

    $display("[TB] reset during third data byte");
    smp_q.delete();
    for (int i = 0; i < 4; i++) smp_q.push_back(8'($urandom));
    build_expected(0);
    applyStimulus(0);
    repeat (45 * 4 - 1) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    checkOutput("midreset_tx", {31'b0, tx[0]}, 32'd1);
    checkOutput("midreset_busy", {31'b0, busy[0]}, 32'd0);
    checkOutput("midreset_frame_done", {31'b0, frame_done[0]}, 32'd0);
    rst[0] = 1'b0;
    pulses = 0;
    tx_low = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (frame_done[0] !== 1'b0) pulses++;
      if (tx[0] !== 1'b1) tx_low++;
    end
    checkOutput("midreset_no_frame_done", pulses, 0);
    checkOutput("midreset_line_idle", tx_low, 0);
    smp_q.delete();
    for (int i = 0; i < 4; i++) smp_q.push_back(8'($urandom));
    build_expected(0);
    applyStimulus(0);
    checkFrame(0, 1'b0);

    $display("[TB] single-sample frames");
    smp_q = '{8'h2D};
    build_expected(1);
    applyStimulus(1);
    checkFrame(1, 1'b0);
    smp_q = '{8'($urandom)};
    build_expected(1);
    applyStimulus(1);
    checkFrame(1, 1'b0);

    $display("[TB] 868 clocks per bit");
    smp_q = '{8'($urandom)};
    build_expected(2);
    applyStimulus(2);
    checkFrame(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
